// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if
//   Request/response bundle for the shared multiplier.
//   Clock and reset are plain ports on the block, not part of this bundle.
//
//   req_valid  [NREQ]        per-requester request strobe, held until accepted
//   req_a      [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      [NREQ*WIDTH]  operand B, same packing
//   req_ready  [NREQ]        one-hot-or-zero grant (combinational)
//   resp_valid [NREQ]        one-hot-or-zero one-cycle result pulse
//   resp_data  [WIDTH]       truncated product, qualified by resp_valid
//   busy                     any pipeline stage holds a valid entry
//
//   master: requester side; slave: mul_share_arb side.
interface mul_share_arb_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_data;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/mul_share_arb.sv
// mul_share_arb
//   Shared MUL_LAT-stage pipelined multiplier fronted by an arbiter. At most
//   one request is accepted per cycle; its truncated product returns to the
//   originating requester as a one-cycle resp_valid pulse exactly MUL_LAT
//   cycles after the accept edge. No stall, no response backpressure.
//
//   Ports:
//     sys_clk    rising-edge clock
//     sys_rst_n  asynchronous active-low reset (flushes the pipeline)
//     bus        mul_share_arb_if.slave request/response bundle
//
//   Build option:
//     MUL_SHARE_FIXED_PRI_EN  defined   -> fixed priority, lowest index wins
//                             undefined -> round-robin starting at ptr
module mul_share_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    mul_share_arb_if.slave  bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  grant_vec;
    logic [PW-1:0]    grant_idx;
    logic             found;
    int unsigned      idx;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] prod_d;

    logic [WIDTH-1:0] prod_q [MUL_LAT];
    logic [PW-1:0]    tag_q  [MUL_LAT];
    logic [MUL_LAT-1:0] v_q;

`ifndef MUL_SHARE_FIXED_PRI_EN
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
`endif

    // Grant the first valid requester in search order.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef MUL_SHARE_FIXED_PRI_EN
            idx = k;
`else
            idx = (32'(ptr_q) + k) % NREQ;
`endif
            if (!found && bus.req_valid[idx]) begin
                found          = 1'b1;
                grant_vec[idx] = 1'b1;
                grant_idx      = PW'(idx);
            end
        end
    end

    // Grant is suppressed combinationally while reset is held.
    assign bus.req_ready = grant_vec & {NREQ{sys_rst_n}};
    assign accept        = |bus.req_ready;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_vec[i]) begin
                a_sel = bus.req_a[i*WIDTH +: WIDTH];
                b_sel = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Assignment context is WIDTH bits, so the product is taken mod 2^WIDTH.
    assign prod_d = a_sel * b_sel;

`ifndef MUL_SHARE_FIXED_PRI_EN
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Free-running pipeline; a cycle without accept injects a bubble.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v_q <= '0;
            for (int unsigned s = 0; s < MUL_LAT; s++) begin
                prod_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            v_q[0]    <= accept;
            prod_q[0] <= prod_d;
            tag_q[0]  <= grant_idx;
            for (int unsigned s = 1; s < MUL_LAT; s++) begin
                v_q[s]    <= v_q[s-1];
                prod_q[s] <= prod_q[s-1];
                tag_q[s]  <= tag_q[s-1];
            end
        end
    end

    assign bus.resp_data = prod_q[MUL_LAT-1];
    assign bus.busy      = |v_q;

    always_comb begin
        bus.resp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (v_q[MUL_LAT-1] && (tag_q[MUL_LAT-1] == PW'(i))) begin
                bus.resp_valid[i] = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned MUL_LAT = 5;

  logic        sys_clk;
  logic        sys_rst_n;
  int unsigned checks;
  int unsigned failures;

  mul_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bif ();

  mul_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bif)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_op(input int unsigned i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bif.req_a[i*WIDTH +: WIDTH] = a;
    bif.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    sys_rst_n     = 1'b0;
    bif.req_valid = 4'b1111;
    bif.req_a     = '0;
    bif.req_b     = '0;

    #2;
    chk("rst_ready", bif.req_ready, 4'b0000);
    chk("rst_resp_valid", bif.resp_valid, 4'b0000);
    chk("rst_resp_data", bif.resp_data, 32'h0);
    chk("rst_busy", bif.busy, 1'b0);
    bif.req_valid = '0;
    tick();
    sys_rst_n = 1'b1;
    tick();

    set_op(0, 32'd7, 32'd6);
    bif.req_valid = 4'b0001;
    #1;
    chk("single_ready", bif.req_ready, 4'b0001);
    tick();
    bif.req_valid = '0;
    chk("single_busy_T", bif.busy, 1'b1);
    for (int unsigned k = 1; k <= 3; k++) begin
      tick();
      chk("single_early_valid", bif.resp_valid, 4'b0000);
      chk("single_busy_mid", bif.busy, 1'b1);
    end
    tick();
    chk("single_resp_valid", bif.resp_valid, 4'b0001);
    chk("single_resp_data", bif.resp_data, 32'd42);
    chk("single_busy_last", bif.busy, 1'b1);
    tick();
    chk("single_pulse_end", bif.resp_valid, 4'b0000);
    chk("single_busy_end", bif.busy, 1'b0);

    do_reset();
    for (int unsigned i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'd10);
    bif.req_valid = 4'b1111;
    #1;
    chk("cont_grant0", bif.req_ready, 4'b0001);
    tick();
    bif.req_valid = 4'b1110;
    #1;
    chk("cont_grant1", bif.req_ready, 4'b0010);
    tick();
    bif.req_valid = 4'b1100;
    #1;
    chk("cont_grant2", bif.req_ready, 4'b0100);
    tick();
    bif.req_valid = 4'b1000;
    #1;
    chk("cont_grant3", bif.req_ready, 4'b1000);
    tick();
    bif.req_valid = '0;
    tick();
    chk("cont_rv0", bif.resp_valid, 4'b0001);
    chk("cont_rd0", bif.resp_data, 32'd10);
    tick();
    chk("cont_rv1", bif.resp_valid, 4'b0010);
    chk("cont_rd1", bif.resp_data, 32'd20);
    tick();
    chk("cont_rv2", bif.resp_valid, 4'b0100);
    chk("cont_rd2", bif.resp_data, 32'd30);
    tick();
    chk("cont_rv3", bif.resp_valid, 4'b1000);
    chk("cont_rd3", bif.resp_data, 32'd40);
    tick();
    chk("cont_drain_rv", bif.resp_valid, 4'b0000);
    chk("cont_drain_busy", bif.busy, 1'b0);

    set_op(0, 32'd2, 32'd3);
    set_op(3, 32'd5, 32'd7);
    bif.req_valid = 4'b1001;
    for (int unsigned j = 0; j < 6; j++) begin
      #1;
`ifdef MUL_SHARE_FIXED_PRI_EN
      chk("wrap_grant", bif.req_ready, 4'b0001);
`else
      chk("wrap_grant", bif.req_ready, (j % 2 == 0) ? 4'b0001 : 4'b1000);
`endif
      tick();
    end
    bif.req_valid = '0;
    for (int unsigned j = 0; j < 5; j++) tick();
    chk("wrap_drain_busy", bif.busy, 1'b0);

    set_op(2, 32'hFFFF_FFFF, 32'd2);
    bif.req_valid = 4'b0100;
    #1;
    chk("trunc_ready", bif.req_ready, 4'b0100);
    tick();
    bif.req_valid = '0;
    for (int unsigned k = 0; k < 3; k++) tick();
    tick();
    chk("trunc_rv", bif.resp_valid, 4'b0100);
    chk("trunc_rd", bif.resp_data, 32'hFFFF_FFFE);
    tick();

    bif.req_valid = 4'b1010;
    #1;
`ifdef MUL_SHARE_FIXED_PRI_EN
    chk("ptr3_grant", bif.req_ready, 4'b0010);
`else
    chk("ptr3_grant", bif.req_ready, 4'b1000);
`endif
    bif.req_valid = '0;
    tick();
    bif.req_valid = 4'b1100;
    #1;
`ifdef MUL_SHARE_FIXED_PRI_EN
    chk("drop_no_effect", bif.req_ready, 4'b0100);
`else
    chk("drop_no_effect", bif.req_ready, 4'b1000);
`endif
    bif.req_valid = '0;
    tick();

    set_op(0, 32'd11, 32'd1);
    set_op(1, 32'd12, 32'd1);
    set_op(2, 32'd13, 32'd1);
    bif.req_valid = 4'b0111;
    tick();
    bif.req_valid = bif.req_valid & ~bif.req_ready;
    tick();
    bif.req_valid = bif.req_valid & ~bif.req_ready;
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bif.req_ready, 4'b0000);
    chk("mid_rst_busy", bif.busy, 1'b0);
    chk("mid_rst_rv", bif.resp_valid, 4'b0000);
    chk("mid_rst_rd", bif.resp_data, 32'h0);
    tick();
    bif.req_valid = '0;
    sys_rst_n = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_no_pulse", bif.resp_valid, 4'b0000);
      chk("post_rst_busy", bif.busy, 1'b0);
    end
    bif.req_valid = 4'b1010;
    #1;
    chk("post_rst_ptr0", bif.req_ready, 4'b0010);
    bif.req_valid = '0;
    tick();

    set_op(1, 32'd3, 32'd4);
    set_op(2, 32'd5, 32'd6);
    set_op(3, 32'd9, 32'd9);
    bif.req_valid = 4'b0010;
    #1;
    chk("bub_ready_T", bif.req_ready, 4'b0010);
    tick();
    bif.req_valid = '0;
    tick();
    bif.req_valid = 4'b0100;
    #1;
    chk("bub_ready_T2", bif.req_ready, 4'b0100);
    tick();
    bif.req_valid = 4'b1000;
    #1;
    chk("bub_ready_T3", bif.req_ready, 4'b1000);
    tick();
    bif.req_valid = '0;
    tick();
    chk("bub_rv0", bif.resp_valid, 4'b0010);
    chk("bub_rd0", bif.resp_data, 32'd12);
    tick();
    chk("bub_gap_rv", bif.resp_valid, 4'b0000);
    chk("bub_gap_busy", bif.busy, 1'b1);
    tick();
    chk("bub_rv1", bif.resp_valid, 4'b0100);
    chk("bub_rd1", bif.resp_data, 32'd30);
    tick();
    chk("bub_rv2", bif.resp_valid, 4'b1000);
    chk("bub_rd2", bif.resp_data, 32'd81);
    tick();
    chk("bub_end_rv", bif.resp_valid, 4'b0000);
    chk("bub_end_busy", bif.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Shared pipelined multiplier with a round-robin arbiter. Up to NREQ scheduled HLS states issue multiply requests, for example the product step of the dot-product datapath. The block grants at most one request per cycle and pushes its operands into a single MUL_LAT-stage multiplier. It returns the truncated product to the originating requester with a one-cycle pulse. Synthesized FSMs use it so that they do not each instantiate a private multiplier.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand and result width
- MUL_LAT, 5, cycles from accept edge to result pulse (1..16)

Ports:
- sys_clk  in  1  clock, rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request strobe; held until accepted
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_ready  out  NREQ  one-hot-or-zero grant (combinational)
- resp_valid  out  NREQ  one-hot-or-zero one-cycle result pulse
- resp_data  out  WIDTH  product, shared by all requesters, qualified by resp_valid
- busy  out  1  high while any pipeline stage holds a valid entry

## Operation
- Request i is accepted on a rising edge where req_valid[i] & req_ready[i] are both high. At most one request is accepted per cycle.
- Arbitration (default): round-robin over the valid requests.
  - Search starts at index ptr and wraps modulo NREQ.
  - The first valid index found is granted.
  - On accept, ptr <= granted+1 (mod NREQ). Without an accept, ptr holds.
  - ptr resets to 0.
- req_ready is combinational from req_valid and ptr. It is forced to 0 while sys_rst_n is low.
- The multiplier pipeline has MUL_LAT stages.
  - Stage 0 captures a*b, tag = granted index, and v = 1.
  - Each subsequent stage shifts every cycle. There is no stall.
- Output: resp_data equals the last-stage product. resp_valid equals the one-hot tag decode gated by the last-stage v.
- Width: product = (a*b) mod 2^WIDTH, unsigned. The same low bits also hold for two's-complement operands.
- The response path has no backpressure. Requesters must sample the result in the pulse cycle.
- busy is the OR of all stage v bits.
- When no request is accepted in a cycle, a bubble (v = 0) enters stage 0.

## Timing
- Reset values: req_ready = 0, resp_valid = 0, resp_data = 0, busy = 0. All stage v bits, tags and products clear to 0, and ptr = 0.
- Latency: a request accepted at edge T produces resp_valid high during the cycle after edge T+MUL_LAT-1, that is, exactly MUL_LAT cycles after the accept edge. The pulse width is 1 cycle.
- Throughput is 1 accept per cycle. Back-to-back accepts from the same or different requesters return in the same order and spacing.
- With a single valid requester, that requester is granted the same cycle, regardless of ptr.
- Simultaneous valids: exactly one is granted. Others hold req_valid and wait.
  - Worst-case wait under round-robin is NREQ-1 cycles.
- Reset asserted mid-operation flushes all in-flight entries. No response is ever emitted for them after reset is released.
- If req_valid drops without being accepted, there is no side effect.

## Configuration
- MUL_SHARE_FIXED_PRI_EN:
  - Defined: fixed priority, where the lowest index wins. ptr is not implemented, and starvation of high indices is permitted.
  - Undefined (default): round-robin as described in Operation.
- Latency, output format and reset behaviour are identical in both modes.

## Test plan
- Single request: the bench drives req_valid=0001 with a=7, b=6 for one accept.
  - Requires req_ready=0001 in the same cycle.
  - Requires resp_valid=0001 and resp_data=42 exactly 5 cycles later (MUL_LAT=5), and busy high for those 5 cycles.
- Contention: all four requesters hold valid, with requester i using a=i+1, b=10.
  - Requires grants in order 0,1,2,3.
  - Requires responses 10,20,30,40 on consecutive cycles, starting 5 cycles after the first accept.
- Wrap and fairness: the bench holds valid on requesters 3 and 0 continuously.
  - Round-robin requires grants to alternate 0,3,0,3 (ptr starts at 0).
  - With MUL_SHARE_FIXED_PRI_EN defined, requires grants 0,0,0,...
- Truncation: the bench drives a=32'hFFFFFFFF, b=2.
  - Requires resp_data=32'hFFFFFFFE.
- Reset mid-flight: the bench issues 3 back-to-back requests, then pulls sys_rst_n low for 1 cycle after the 2nd edge.
  - Requires no resp_valid pulse afterward.
  - Requires busy=0, ptr=0, and outputs at their reset values.
- Bubble spacing: the bench accepts requests at edges T, T+2 and T+3.
  - Requires pulses at T+5, T+7 and T+8 with matching tags, and resp_valid low at T+6.
